// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM device-side responder model.
package sdram_pkg;

  localparam int unsigned NUM_BANKS   = 4;
  localparam int unsigned BA_W        = 2;
  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned A10_BIT     = 10;
  localparam int unsigned MODE_CL_LSB = 4;
  localparam int unsigned MODE_CL_W   = 3;
  localparam int unsigned MODE_BL_LSB = 0;
  localparam int unsigned MODE_BL_W   = 3;

  localparam int unsigned ERR_W         = 4;
  localparam int unsigned ERR_RW_CLOSED = 0;
  localparam int unsigned ERR_ACT_OPEN  = 1;
  localparam int unsigned ERR_BANK_OPEN = 2;
  localparam int unsigned ERR_BAD_MODE  = 3;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_LOAD_MODE
  } cmd_e;

  // Stored mode register: CL is only ever 2 or 3, BL code 0..3 => 1/2/4/8.
  typedef struct packed {
    logic       cl3;
    logic [1:0] bl_code;
  } mode_t;

  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACTIVE;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b010:  c = CMD_PRECHARGE;
        3'b001:  c = CMD_REFRESH;
        3'b000:  c = CMD_LOAD_MODE;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic mode_legal(input logic [ADDR_W-1:0] addr);
    logic [MODE_CL_W-1:0] cl;
    logic [MODE_BL_W-1:0] bl;
    cl = addr[MODE_CL_LSB +: MODE_CL_W];
    bl = addr[MODE_BL_LSB +: MODE_BL_W];
    return ((cl == 3'd2) || (cl == 3'd3)) && (bl <= 3'd3);
  endfunction

  function automatic mode_t mode_decode(input logic [ADDR_W-1:0] addr);
    mode_t m;
    m.cl3     = (addr[MODE_CL_LSB +: MODE_CL_W] == 3'd3);
    m.bl_code = addr[MODE_BL_LSB +: 2];
    return m;
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open flag and open-row registers with a single lookup port.
module sdram_bank_tracker
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 open_en,
  input  logic [BA_W-1:0]      open_ba,
  input  logic [ROW_W-1:0]     open_row,
  input  logic [NUM_BANKS-1:0] close_mask,
  input  logic [BA_W-1:0]      lookup_ba,
  output logic                 lookup_open_c,
  output logic [ROW_W-1:0]     lookup_row_c,
  output logic                 any_open_c
);

  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_W-1:0]     row_q [NUM_BANKS];

  // Open only ever targets a closed bank, so open and close never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) row_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (close_mask[b]) open_q[b] <= 1'b0;
        if (open_en && (open_ba == BA_W'(b))) begin
          open_q[b] <= 1'b1;
          row_q[b]  <= open_row;
        end
      end
    end
  end

  assign lookup_open_c = open_q[lookup_ba];
  assign lookup_row_c  = row_q[lookup_ba];
  assign any_open_c    = |open_q;

endmodule

// File: rtl/sdram_mem_responder.sv
// Cycle-level SDRAM device model: command decode, bursts against a word
// array, CAS-latency read pipe and sticky protocol error flags.
module sdram_mem_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned DW        = 16,
  parameter int unsigned REF_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sdram_cke_i,
  input  logic                 sdram_cs_i,
  input  logic                 sdram_ras_i,
  input  logic                 sdram_cas_i,
  input  logic                 sdram_we_i,
  input  logic [1:0]           sdram_dqm_i,
  input  logic [ADDR_W-1:0]    sdram_addr_i,
  input  logic [BA_W-1:0]      sdram_ba_i,
  input  logic [DW-1:0]        sdram_data_i,
  output logic [DW-1:0]        sdram_data_o,
  output logic                 sdram_data_oe_o,
  output logic                 mode_loaded_o,
  output logic [REF_CNT_W-1:0] refresh_cnt_o,
  output logic [ERR_W-1:0]     err_o
);

  localparam int unsigned AW     = BA_W + ROW_W + COL_W;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned LANES  = 2;
  localparam int unsigned LANE_W = DW / LANES;
  localparam int unsigned LEFT_W = 4;

  typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_e;

  function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] col,
                                                input logic [1:0] bl_code);
    logic [COL_W-1:0] mask;
    mask = COL_W'((1 << bl_code) - 1);
    return (col & ~mask) | ((col + COL_W'(1)) & mask);
  endfunction

  function automatic logic [DW-1:0] lane_zero(input logic [DW-1:0] d,
                                              input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    r = d;
    for (int b = 0; b < LANES; b++) if (m[b]) r[b*LANE_W +: LANE_W] = '0;
    return r;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  burst_e         burst_q, burst_d;
  logic [BA_W-1:0]   b_ba_q, b_ba_d;
  logic [ROW_W-1:0]  b_row_q, b_row_d;
  logic [COL_W-1:0]  b_col_q, b_col_d;
  logic [LEFT_W-1:0] b_left_q, b_left_d;
  logic [1:0]        b_bl_q, b_bl_d;
  logic              b_ap_q, b_ap_d;

  logic          s1_vld_q, s1_vld_d, s1_cl3_q, s1_cl3_d, s2_vld_q, s2_vld_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [1:0]    dqm_q, dqm_d;

  mode_t                mode_q, mode_d;
  logic                 loaded_q, loaded_d;
  logic [REF_CNT_W-1:0] ref_q, ref_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 oe_q, oe_d;

  logic                 open_en;
  logic [NUM_BANKS-1:0] close_mask;
  logic                 lookup_open_c, any_open_c;
  logic [ROW_W-1:0]     lookup_row_c;

  logic            mem_we, rd_issue;
  logic [AW-1:0]   mem_waddr, rd_addr;

  cmd_e            cmd_c;
  logic            a10_c, rw_go_c, out_due_c, unused_addr_c;
  logic [COL_W-1:0] col_c;
  logic [AW-1:0]   out_addr_c;
  logic [DW-1:0]   out_word_c;

  assign cmd_c         = decode_cmd(sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i);
  assign a10_c         = sdram_addr_i[A10_BIT];
  assign col_c         = sdram_addr_i[COL_W-1:0];
  assign unused_addr_c = ^sdram_addr_i;
  assign rw_go_c       = sdram_cke_i && ((cmd_c == CMD_READ) || (cmd_c == CMD_WRITE))
                         && lookup_open_c && loaded_q;
  assign out_due_c     = s2_vld_q || (s1_vld_q && !s1_cl3_q);
  assign out_addr_c    = s2_vld_q ? s2_addr_q : s1_addr_q;
  assign out_word_c    = mem[out_addr_c];

  sdram_bank_tracker #(.ROW_W(ROW_W)) u_banks (
    .clk           (clk_i),
    .rst_n         (rst_n_i),
    .open_en       (open_en),
    .open_ba       (sdram_ba_i),
    .open_row      (sdram_addr_i[ROW_W-1:0]),
    .close_mask    (close_mask),
    .lookup_ba     (sdram_ba_i),
    .lookup_open_c (lookup_open_c),
    .lookup_row_c  (lookup_row_c),
    .any_open_c    (any_open_c)
  );

  // Next-state: pipe advance, burst continuation, then the new command.
  always_comb begin
    burst_d    = burst_q;
    b_ba_d     = b_ba_q;
    b_row_d    = b_row_q;
    b_col_d    = b_col_q;
    b_left_d   = b_left_q;
    b_bl_d     = b_bl_q;
    b_ap_d     = b_ap_q;
    s1_vld_d   = s1_vld_q;
    s1_cl3_d   = s1_cl3_q;
    s1_addr_d  = s1_addr_q;
    s2_vld_d   = s2_vld_q;
    s2_addr_d  = s2_addr_q;
    dqm_d      = dqm_q;
    mode_d     = mode_q;
    loaded_d   = loaded_q;
    ref_d      = ref_q;
    err_d      = err_q;
    data_d     = data_q;
    oe_d       = oe_q;
    open_en    = 1'b0;
    close_mask = '0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    rd_issue   = 1'b0;
    rd_addr    = '0;

    if (sdram_cke_i) begin
      dqm_d     = sdram_dqm_i;
      s2_vld_d  = s1_vld_q && s1_cl3_q;
      s2_addr_d = s1_addr_q;
      s1_vld_d  = 1'b0;
      oe_d      = out_due_c;
      data_d    = out_due_c ? lane_zero(out_word_c, dqm_q) : '0;

      if ((burst_q != BURST_IDLE) && !rw_go_c) begin
        if (burst_q == BURST_WRITE) begin
          mem_we    = 1'b1;
          mem_waddr = {b_ba_q, b_row_q, b_col_q};
        end else begin
          rd_issue = 1'b1;
          rd_addr  = {b_ba_q, b_row_q, b_col_q};
        end
        b_col_d  = col_next(b_col_q, b_bl_q);
        b_left_d = b_left_q - LEFT_W'(1);
        if (b_left_q == LEFT_W'(1)) begin
          burst_d = BURST_IDLE;
          if (b_ap_q) close_mask[b_ba_q] = 1'b1;
        end
      end

      case (cmd_c)
        CMD_ACTIVE: begin
          if (lookup_open_c) err_d[ERR_ACT_OPEN] = 1'b1;
          else               open_en = 1'b1;
        end
        CMD_PRECHARGE: begin
          if (a10_c) close_mask = '1;
          else       close_mask[sdram_ba_i] = 1'b1;
        end
        CMD_REFRESH: begin
          ref_d = ref_q + REF_CNT_W'(1);
          if (any_open_c) err_d[ERR_BANK_OPEN] = 1'b1;
        end
        CMD_LOAD_MODE: begin
          if (any_open_c) err_d[ERR_BANK_OPEN] = 1'b1;
          if (!mode_legal(sdram_addr_i)) err_d[ERR_BAD_MODE] = 1'b1;
          if (!any_open_c && mode_legal(sdram_addr_i)) begin
            mode_d   = mode_decode(sdram_addr_i);
            loaded_d = 1'b1;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (!rw_go_c) begin
            err_d[ERR_RW_CLOSED] = 1'b1;
          end else begin
            if (cmd_c == CMD_WRITE) begin
              // Turnaround: any read beats still in flight are dropped.
              mem_we    = 1'b1;
              mem_waddr = {sdram_ba_i, lookup_row_c, col_c};
              s1_vld_d  = 1'b0;
              s2_vld_d  = 1'b0;
              oe_d      = 1'b0;
              data_d    = '0;
            end else begin
              rd_issue = 1'b1;
              rd_addr  = {sdram_ba_i, lookup_row_c, col_c};
            end
            if (mode_q.bl_code == 2'd0) begin
              burst_d = BURST_IDLE;
              if (a10_c) close_mask[sdram_ba_i] = 1'b1;
            end else begin
              burst_d  = (cmd_c == CMD_WRITE) ? BURST_WRITE : BURST_READ;
              b_ba_d   = sdram_ba_i;
              b_row_d  = lookup_row_c;
              b_col_d  = col_next(col_c, mode_q.bl_code);
              b_left_d = LEFT_W'((1 << mode_q.bl_code) - 1);
              b_bl_d   = mode_q.bl_code;
              b_ap_d   = a10_c;
            end
          end
        end
        default: ;
      endcase

      if (rd_issue) begin
        s1_vld_d  = 1'b1;
        s1_cl3_d  = mode_q.cl3;
        s1_addr_d = rd_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_q   <= BURST_IDLE;
      b_ba_q    <= '0;
      b_row_q   <= '0;
      b_col_q   <= '0;
      b_left_q  <= '0;
      b_bl_q    <= '0;
      b_ap_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_cl3_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      dqm_q     <= '0;
      mode_q    <= '0;
      loaded_q  <= 1'b0;
      ref_q     <= '0;
      err_q     <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      burst_q   <= burst_d;
      b_ba_q    <= b_ba_d;
      b_row_q   <= b_row_d;
      b_col_q   <= b_col_d;
      b_left_q  <= b_left_d;
      b_bl_q    <= b_bl_d;
      b_ap_q    <= b_ap_d;
      s1_vld_q  <= s1_vld_d;
      s1_cl3_q  <= s1_cl3_d;
      s1_addr_q <= s1_addr_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      dqm_q     <= dqm_d;
      mode_q    <= mode_d;
      loaded_q  <= loaded_d;
      ref_q     <= ref_d;
      err_q     <= err_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  // Storage is deliberately not reset; masked lanes keep their old contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (!sdram_dqm_i[b]) mem[mem_waddr][b*LANE_W +: LANE_W] <= sdram_data_i[b*LANE_W +: LANE_W];
      end
    end
  end

  assign sdram_data_o    = data_q;
  assign sdram_data_oe_o = oe_q;
  assign mode_loaded_o   = loaded_q;
  assign refresh_cnt_o   = ref_q;
  assign err_o           = err_q;

endmodule
